mig_axi_burst_master: RTL and testbench

- AXI4 initiator that drives the s_axi_* slave port of the MIG DDR3 controller.
- Converts one line-sized read or write request from the core/cache side into a single INCR burst of BURST_LEN beats.
- Streams the burst beats through ready/valid ports and reports completion and response errors.
- Lives entirely in the MIG ui_clk domain, between the memory-side cache and mig_7series_0_axi.

---
 rtl/mig_axi_pkg.sv | 31 +++
 rtl/mig_axi_burst_master.sv | 213 +++++++++++++++++++++
 tb/tb_mig_axi_burst_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_axi_pkg.sv
// Shared types and AXI constants for the MIG AXI burst master.
package mig_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // ceil(log2(n)); used for AXI size and line alignment
  function automatic int unsigned log2_size(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp & 2'b10) != (RESP_OKAY & 2'b10);
  endfunction

endpackage

// File: rtl/mig_axi_burst_master.sv
// Single-line INCR burst AXI4 master for the MIG DDR3 s_axi port (ui_clk domain).
// Optional stall watchdog with o_timeout: define MIG_AXI_TIMEOUT_EN.
module mig_axi_burst_master
  import mig_axi_pkg::*;
#(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16,
  parameter int unsigned BURST_LEN      = 4,
  parameter logic [3:0]  AXI_ID         = 4'd0
) (
  input  logic                      ui_clk,
  input  logic                      ui_rst,
  input  logic                      init_calib_complete,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [APP_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_wdata,
  input  logic [APP_MASK_WIDTH-1:0] i_wstrb,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [APP_DATA_WIDTH-1:0] o_rdata,
  output logic                      o_rvalid,
  output logic                      o_rlast,
  input  logic                      i_rready,
  output logic                      o_done,
  output logic                      o_err,
  output logic                      o_busy,
`ifdef MIG_AXI_TIMEOUT_EN
  output logic                      o_timeout,
`endif
  output logic [3:0]                s_axi_awid,
  output logic [APP_ADDR_WIDTH-1:0] s_axi_awaddr,
  output logic [7:0]                s_axi_awlen,
  output logic [2:0]                s_axi_awsize,
  output logic [1:0]                s_axi_awburst,
  output logic                      s_axi_awlock,
  output logic [3:0]                s_axi_awcache,
  output logic [2:0]                s_axi_awprot,
  output logic [3:0]                s_axi_awqos,
  output logic                      s_axi_awvalid,
  input  logic                      s_axi_awready,
  output logic [APP_DATA_WIDTH-1:0] s_axi_wdata,
  output logic [APP_MASK_WIDTH-1:0] s_axi_wstrb,
  output logic                      s_axi_wlast,
  output logic                      s_axi_wvalid,
  input  logic                      s_axi_wready,
  input  logic [3:0]                s_axi_bid,
  input  logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_bvalid,
  output logic                      s_axi_bready,
  output logic [3:0]                s_axi_arid,
  output logic [APP_ADDR_WIDTH-1:0] s_axi_araddr,
  output logic [7:0]                s_axi_arlen,
  output logic [2:0]                s_axi_arsize,
  output logic [1:0]                s_axi_arburst,
  output logic                      s_axi_arlock,
  output logic [3:0]                s_axi_arcache,
  output logic [2:0]                s_axi_arprot,
  output logic [3:0]                s_axi_arqos,
  output logic                      s_axi_arvalid,
  input  logic                      s_axi_arready,
  input  logic [3:0]                s_axi_rid,
  input  logic [APP_DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]                s_axi_rresp,
  input  logic                      s_axi_rlast,
  input  logic                      s_axi_rvalid,
  output logic                      s_axi_rready
);

  localparam int unsigned SIZE  = log2_size(APP_MASK_WIDTH);
  localparam int unsigned ALIGN = log2_size(BURST_LEN * APP_MASK_WIDTH);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [APP_ADDR_WIDTH-1:0] LINE_MASK =
    APP_ADDR_WIDTH'((64'd1 << ALIGN) - 64'd1);

  state_t                    state, state_nx;
  logic [7:0]                beat_cnt, beat_cnt_nx;
  logic                      err_acc, err_acc_nx;
  logic                      done_q, done_nx, err_q, err_nx;
  logic [APP_ADDR_WIDTH-1:0] addr_q;
  logic                      accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                      unused_ok;

  assign unused_ok = ^{s_axi_bid, s_axi_rid};

  // Ready is held low during reset even though the state already reads IDLE
  assign o_req_ready = (state == IDLE) & init_calib_complete & ~ui_rst;
  assign accept      = o_req_ready & i_req_valid;
  assign o_busy      = (state != IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;

  assign s_axi_awid    = AXI_ID;
  assign s_axi_awaddr  = addr_q;
  assign s_axi_awlen   = LAST_BEAT;
  assign s_axi_awsize  = 3'(SIZE);
  assign s_axi_awburst = BURST_INCR;
  assign s_axi_awlock  = 1'b0;
  assign s_axi_awcache = '0;
  assign s_axi_awprot  = '0;
  assign s_axi_awqos   = '0;
  assign s_axi_awvalid = (state == AW);
  assign aw_hs         = s_axi_awvalid & s_axi_awready;

  assign s_axi_wdata  = i_wdata;
  assign s_axi_wstrb  = i_wstrb;
  assign s_axi_wvalid = (state == W) & i_wvalid;
  assign o_wready     = (state == W) & s_axi_wready;
  assign s_axi_wlast  = (state == W) & (beat_cnt == LAST_BEAT);
  assign w_hs         = s_axi_wvalid & s_axi_wready;

  assign s_axi_bready = (state == B);
  assign b_hs         = s_axi_bready & s_axi_bvalid;

  assign s_axi_arid    = AXI_ID;
  assign s_axi_araddr  = addr_q;
  assign s_axi_arlen   = LAST_BEAT;
  assign s_axi_arsize  = 3'(SIZE);
  assign s_axi_arburst = BURST_INCR;
  assign s_axi_arlock  = 1'b0;
  assign s_axi_arcache = '0;
  assign s_axi_arprot  = '0;
  assign s_axi_arqos   = '0;
  assign s_axi_arvalid = (state == AR);
  assign ar_hs         = s_axi_arvalid & s_axi_arready;

  assign s_axi_rready = (state == R) & i_rready;
  assign o_rvalid     = (state == R) & s_axi_rvalid;
  assign o_rlast      = (state == R) & s_axi_rlast;
  assign o_rdata      = s_axi_rdata;
  assign r_hs         = o_rvalid & s_axi_rready;

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
      err_acc  <= err_acc_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
      if (accept) addr_q <= i_req_addr & ~LINE_MASK;
    end
  end

  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    err_acc_nx  = err_acc;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nx    = i_req_we ? AW : AR;
        beat_cnt_nx = '0;
        err_acc_nx  = 1'b0;
      end
      AW: if (aw_hs) state_nx = W;
      W: if (w_hs) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt_nx = '0;
          state_nx    = B;
        end else begin
          beat_cnt_nx = beat_cnt + 8'd1;
        end
      end
      B: if (b_hs) begin
        done_nx  = 1'b1;
        err_nx   = resp_is_err(s_axi_bresp);
        state_nx = IDLE;
      end
      AR: if (ar_hs) state_nx = R;
      R: if (r_hs) begin
        err_acc_nx  = err_acc | resp_is_err(s_axi_rresp);
        beat_cnt_nx = beat_cnt + 8'd1;
        // A short burst (rlast before the final beat) is itself an error
        if (s_axi_rlast) begin
          done_nx     = 1'b1;
          err_nx      = err_acc_nx | (beat_cnt != LAST_BEAT);
          beat_cnt_nx = '0;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MIG_AXI_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        any_hs;

  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      stall_cnt <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (state == IDLE || any_hs) stall_cnt <= '0;
      else if (stall_cnt != '1)    stall_cnt <= stall_cnt + 16'd1;
      if (stall_cnt == '1) o_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mig_axi_burst_master.sv
// Cycle-vector bench for mig_axi_burst_master: table of per-cycle stimulus/expectations plus
// hand sequences for reset abort, AW back-pressure and (with MIG_AXI_TIMEOUT_EN) the watchdog.
module tb_mig_axi_burst_master;

  // stimulus flags
  localparam int I_CAL = 1 << 0, I_REQ = 1 << 1, I_WE = 1 << 2, I_AWR = 1 << 3, I_ARR = 1 << 4,
                 I_WV  = 1 << 5, I_WR  = 1 << 6, I_BV = 1 << 7, I_RV  = 1 << 8, I_RL  = 1 << 9,
                 I_RR  = 1 << 10;
  // expected-output flags
  localparam int E_RDY = 1 << 0, E_AWV = 1 << 1, E_ARV = 1 << 2, E_WV  = 1 << 3, E_WR   = 1 << 4,
                 E_WL  = 1 << 5, E_BR  = 1 << 6, E_RV  = 1 << 7, E_RL  = 1 << 8, E_RR   = 1 << 9,
                 E_DONE = 1 << 10, E_ERR = 1 << 11, E_BUSY = 1 << 12;

  logic         ui_clk = 1'b0;
  logic         ui_rst;
  logic         init_calib_complete, i_req_valid, o_req_ready, i_req_we;
  logic [27:0]  i_req_addr;
  logic [127:0] i_wdata, o_rdata;
  logic [15:0]  i_wstrb;
  logic         i_wvalid, o_wready, o_rvalid, o_rlast, i_rready, o_done, o_err, o_busy;
`ifdef MIG_AXI_TIMEOUT_EN
  logic         o_timeout;
`endif
  logic [3:0]   s_axi_awid, s_axi_awcache, s_axi_awqos, s_axi_arid, s_axi_arcache, s_axi_arqos;
  logic [27:0]  s_axi_awaddr, s_axi_araddr;
  logic [7:0]   s_axi_awlen, s_axi_arlen;
  logic [2:0]   s_axi_awsize, s_axi_awprot, s_axi_arsize, s_axi_arprot;
  logic [1:0]   s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic         s_axi_awlock, s_axi_awvalid, s_axi_awready, s_axi_arlock, s_axi_arvalid, s_axi_arready;
  logic [127:0] s_axi_wdata, s_axi_rdata;
  logic [15:0]  s_axi_wstrb;
  logic         s_axi_wlast, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic [3:0]   s_axi_bid, s_axi_rid;
  logic         s_axi_rlast, s_axi_rvalid, s_axi_rready;

  always #5 ui_clk = ~ui_clk;

  mig_axi_burst_master #(.APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16),
                         .BURST_LEN(4), .AXI_ID(4'd0)) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .init_calib_complete(init_calib_complete),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid),
    .o_wready(o_wready), .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rlast(o_rlast),
    .i_rready(i_rready), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
`ifdef MIG_AXI_TIMEOUT_EN
    .o_timeout(o_timeout),
`endif
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  typedef struct {
    int          ins;
    logic [27:0] addr;
    logic [1:0]  resp;
    logic [7:0]  data;
    int          exp;
    logic [27:0] exp_addr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec, n_bad;

  task automatic add(input int ins, input logic [27:0] addr, input logic [1:0] resp,
                     input logic [7:0] data, input int exp, input logic [27:0] exp_addr);
    tbl.push_back('{ins, addr, resp, data, exp, exp_addr});
  endtask

  task automatic drive(input int f, input logic [27:0] a, input logic [1:0] r, input logic [7:0] d);
    init_calib_complete = (f & I_CAL) != 0;
    i_req_valid   = (f & I_REQ) != 0;
    i_req_we      = (f & I_WE)  != 0;
    s_axi_awready = (f & I_AWR) != 0;
    s_axi_arready = (f & I_ARR) != 0;
    i_wvalid      = (f & I_WV)  != 0;
    s_axi_wready  = (f & I_WR)  != 0;
    s_axi_bvalid  = (f & I_BV)  != 0;
    s_axi_rvalid  = (f & I_RV)  != 0;
    s_axi_rlast   = (f & I_RL)  != 0;
    i_rready      = (f & I_RR)  != 0;
    i_req_addr    = a;
    s_axi_bresp   = r;
    s_axi_rresp   = r;
    i_wdata       = {16{d}};
    i_wstrb       = {2{d}};
    s_axi_rdata   = {16{d}};
    s_axi_bid     = 4'h5;
    s_axi_rid     = 4'h5;
  endtask

  function automatic int obs();
    return (int'(o_req_ready)   << 0)  | (int'(s_axi_awvalid) << 1)  | (int'(s_axi_arvalid) << 2) |
           (int'(s_axi_wvalid)  << 3)  | (int'(o_wready)      << 4)  | (int'(s_axi_wlast)   << 5) |
           (int'(s_axi_bready)  << 6)  | (int'(o_rvalid)      << 7)  | (int'(o_rlast)       << 8) |
           (int'(s_axi_rready)  << 9)  | (int'(o_done)        << 10) | (int'(o_done & o_err) << 11) |
           (int'(o_busy)        << 12);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    ui_rst = 1'b1;
    drive(I_CAL | I_REQ | I_WE | I_AWR | I_ARR | I_WV | I_WR | I_BV | I_RV | I_RL | I_RR,
          28'h000123A, 2'b00, 8'h5A);
    repeat (2) @(negedge ui_clk);
    #1;
    chk("reset_outputs", 128'(obs()), 128'(0));
    chk("const_aw", 128'({s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
                          s_axi_awcache, s_axi_awprot, s_axi_awqos}),
        128'({4'd0, 8'd3, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
    chk("const_ar", 128'({s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
                          s_axi_arcache, s_axi_arprot, s_axi_arqos}),
        128'({4'd0, 8'd3, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
    @(negedge ui_clk);
    drive(I_CAL, 28'h0, 2'b00, 8'h00);
    ui_rst = 1'b0;

    // write 0x123A -> line 0x1200, with back-pressure and a gap
    add(I_CAL | I_REQ | I_WE, 28'h000123A, 2'b00, 8'h00, E_RDY, 28'h0);
    add(I_CAL,                        28'h0, 2'b00, 8'h00, E_AWV | E_BUSY, 28'h0001200);
    add(I_CAL | I_AWR | I_WV | I_WR,  28'h0, 2'b00, 8'hA0, E_AWV | E_BUSY, 28'h0001200);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hA1, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hA2, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WR,        28'h0, 2'b00, 8'h00, E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV,        28'h0, 2'b00, 8'hA3, E_WV | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hA3, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hA4, E_WV | E_WR | E_WL | E_BUSY, 28'h0);
    add(I_CAL,               28'h0, 2'b00, 8'h00, E_BR | E_BUSY, 28'h0);
    add(I_CAL | I_BV,        28'h0, 2'b00, 8'h00, E_BR | E_BUSY, 28'h0);
    add(I_CAL,               28'h0, 2'b00, 8'h00, E_RDY | E_DONE, 28'h0);
    add(I_CAL,               28'h0, 2'b00, 8'h00, E_RDY, 28'h0);
    // read 0x040 with i_rready toggling
    add(I_CAL | I_REQ, 28'h0000040, 2'b00, 8'h00, E_RDY, 28'h0);
    add(I_CAL,         28'h0, 2'b00, 8'h00, E_ARV | E_BUSY, 28'h0000040);
    add(I_CAL | I_ARR, 28'h0, 2'b00, 8'h00, E_ARV | E_BUSY, 28'h0000040);
    add(I_CAL | I_RV | I_RR, 28'h0, 2'b00, 8'h11, E_RV | E_RR | E_BUSY, 28'h0);
    add(I_CAL | I_RV,        28'h0, 2'b00, 8'h22, E_RV | E_BUSY, 28'h0);
    add(I_CAL | I_RV | I_RR, 28'h0, 2'b00, 8'h22, E_RV | E_RR | E_BUSY, 28'h0);
    add(I_CAL | I_RV,        28'h0, 2'b00, 8'h33, E_RV | E_BUSY, 28'h0);
    add(I_CAL | I_RV | I_RR, 28'h0, 2'b00, 8'h33, E_RV | E_RR | E_BUSY, 28'h0);
    add(I_CAL | I_RV | I_RL, 28'h0, 2'b00, 8'h44, E_RV | E_RL | E_BUSY, 28'h0);
    add(I_CAL | I_RV | I_RL | I_RR, 28'h0, 2'b00, 8'h44, E_RV | E_RL | E_RR | E_BUSY, 28'h0);
    add(I_CAL,         28'h0, 2'b00, 8'h00, E_RDY | E_DONE, 28'h0);
    // calibration gating, then read with SLVERR on beat 2 while calibration drops
    add(I_REQ,         28'h0000ABC, 2'b00, 8'h00, 0, 28'h0);
    add(I_REQ,         28'h0000ABC, 2'b00, 8'h00, 0, 28'h0);
    add(I_CAL | I_REQ, 28'h0000ABC, 2'b00, 8'h00, E_RDY, 28'h0);
    add(0,             28'h0, 2'b00, 8'h00, E_ARV | E_BUSY, 28'h0000A80);
    add(I_ARR,         28'h0, 2'b00, 8'h00, E_ARV | E_BUSY, 28'h0000A80);
    add(I_RV | I_RR,   28'h0, 2'b00, 8'h01, E_RV | E_RR | E_BUSY, 28'h0);
    add(I_RV | I_RR,   28'h0, 2'b10, 8'h02, E_RV | E_RR | E_BUSY, 28'h0);
    add(I_RV | I_RR,   28'h0, 2'b00, 8'h03, E_RV | E_RR | E_BUSY, 28'h0);
    add(I_RV | I_RR | I_RL, 28'h0, 2'b00, 8'h04, E_RV | E_RR | E_RL | E_BUSY, 28'h0);
    add(I_CAL,         28'h0, 2'b00, 8'h00, E_RDY | E_DONE | E_ERR, 28'h0);
    // early rlast after 2 beats
    add(I_CAL | I_REQ, 28'h0000100, 2'b00, 8'h00, E_RDY, 28'h0);
    add(I_CAL | I_ARR, 28'h0, 2'b00, 8'h00, E_ARV | E_BUSY, 28'h0000100);
    add(I_CAL | I_RV | I_RR, 28'h0, 2'b00, 8'h55, E_RV | E_RR | E_BUSY, 28'h0);
    add(I_CAL | I_RV | I_RR | I_RL, 28'h0, 2'b00, 8'h66, E_RV | E_RR | E_RL | E_BUSY, 28'h0);
    add(I_CAL,         28'h0, 2'b00, 8'h00, E_RDY | E_DONE | E_ERR, 28'h0);
    // top-of-memory write with SLVERR, then one with EXOKAY
    add(I_CAL | I_REQ | I_WE, 28'hFFFFFFF, 2'b00, 8'h00, E_RDY, 28'h0);
    add(I_CAL | I_AWR, 28'h0, 2'b00, 8'h00, E_AWV | E_BUSY, 28'hFFFFFC0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hB1, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hB2, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hB3, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hB4, E_WV | E_WR | E_WL | E_BUSY, 28'h0);
    add(I_CAL | I_BV,  28'h0, 2'b10, 8'h00, E_BR | E_BUSY, 28'h0);
    add(I_CAL,         28'h0, 2'b00, 8'h00, E_RDY | E_DONE | E_ERR, 28'h0);
    add(I_CAL | I_REQ | I_WE, 28'h0000047, 2'b00, 8'h00, E_RDY, 28'h0);
    add(I_CAL | I_AWR, 28'h0, 2'b00, 8'h00, E_AWV | E_BUSY, 28'h0000040);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hC1, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hC2, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hC3, E_WV | E_WR | E_BUSY, 28'h0);
    add(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hC4, E_WV | E_WR | E_WL | E_BUSY, 28'h0);
    add(I_CAL | I_BV,  28'h0, 2'b01, 8'h00, E_BR | E_BUSY, 28'h0);
    add(I_CAL,         28'h0, 2'b00, 8'h00, E_RDY | E_DONE, 28'h0);

    foreach (tbl[i]) begin
      @(negedge ui_clk);
      drive(tbl[i].ins, tbl[i].addr, tbl[i].resp, tbl[i].data);
      #1;
      chk($sformatf("vec%0d_flags", i), 128'(obs()), 128'(tbl[i].exp));
      if ((tbl[i].exp & E_AWV) != 0) chk($sformatf("vec%0d_awaddr", i), 128'(s_axi_awaddr), 128'(tbl[i].exp_addr));
      if ((tbl[i].exp & E_ARV) != 0) chk($sformatf("vec%0d_araddr", i), 128'(s_axi_araddr), 128'(tbl[i].exp_addr));
      if ((tbl[i].exp & E_RV) != 0)  chk($sformatf("vec%0d_rdata", i), o_rdata, {16{tbl[i].data}});
      if ((tbl[i].exp & E_WV) != 0) begin
        chk($sformatf("vec%0d_wdata", i), s_axi_wdata, {16{tbl[i].data}});
        chk($sformatf("vec%0d_wstrb", i), 128'(s_axi_wstrb), 128'({2{tbl[i].data}}));
      end
    end

    // reset asserted during write beat 2
    @(negedge ui_clk); drive(I_CAL | I_REQ | I_WE, 28'h0000080, 2'b00, 8'h00);
    @(negedge ui_clk); drive(I_CAL | I_AWR, 28'h0, 2'b00, 8'h00);
    @(negedge ui_clk); drive(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hD1);
    @(negedge ui_clk); drive(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hD2);
    #1 chk("pre_reset_w", 128'(obs()), 128'(E_WV | E_WR | E_BUSY));
    #1 ui_rst = 1'b1;
    #1 chk("reset_mid_w", 128'(obs()), 128'(0));
    @(negedge ui_clk);
    ui_rst = 1'b0;
    drive(I_CAL, 28'h0, 2'b00, 8'h00);
    #1 chk("idle_after_reset", 128'(obs()), 128'(E_RDY));
    @(negedge ui_clk);
    #1 chk("no_done_after_reset", 128'(obs()), 128'(E_RDY));

    // awready withheld 20 cycles while write data is already offered
    @(negedge ui_clk); drive(I_CAL | I_REQ | I_WE, 28'h0002345, 2'b00, 8'h00);
    #1 chk("stall_accept", 128'(obs()), 128'(E_RDY));
    for (int c = 0; c < 20; c++) begin
      @(negedge ui_clk); drive(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'hE0);
      #1 chk($sformatf("aw_stall%0d", c),
             128'({s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, o_wready}),
             128'({1'b1, 28'h0002340, 1'b0, 1'b0}));
    end
    @(negedge ui_clk); drive(I_CAL | I_AWR | I_WV | I_WR, 28'h0, 2'b00, 8'hE0);
    #1 chk("stall_aw_hs", 128'(obs()), 128'(E_AWV | E_BUSY));
    for (int b = 0; b < 4; b++) begin
      @(negedge ui_clk); drive(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'(b));
      #1 chk($sformatf("stall_beat%0d_wlast", b), 128'({s_axi_wvalid, s_axi_wlast}),
             128'({1'b1, (b == 3) ? 1'b1 : 1'b0}));
    end
    @(negedge ui_clk); drive(I_CAL | I_BV, 28'h0, 2'b00, 8'h00);
    #1 chk("stall_b", 128'(obs()), 128'(E_BR | E_BUSY));
    @(negedge ui_clk); drive(I_CAL, 28'h0, 2'b00, 8'h00);
    #1 chk("stall_done", 128'(obs()), 128'(E_RDY | E_DONE));

`ifdef MIG_AXI_TIMEOUT_EN
    begin
      int cyc;
      @(negedge ui_clk); drive(I_CAL | I_REQ | I_WE, 28'h0, 2'b00, 8'h00);
      @(negedge ui_clk); drive(I_CAL | I_AWR, 28'h0, 2'b00, 8'h00);
      for (int b = 0; b < 4; b++) begin
        @(negedge ui_clk); drive(I_CAL | I_WV | I_WR, 28'h0, 2'b00, 8'h00);
      end
      @(negedge ui_clk); drive(I_CAL, 28'h0, 2'b00, 8'h00);
      #1 chk("timeout_clear", 128'(o_timeout), 128'(0));
      cyc = 0;
      while (!o_timeout && cyc < 70000) begin
        @(negedge ui_clk);
        #1 cyc++;
      end
      chk("timeout_set", 128'(o_timeout), 128'(1));
      chk("timeout_not_early", 128'(cyc >= 65000), 128'(1));
      chk("timeout_state_kept", 128'(obs()), 128'(E_BR | E_BUSY));
      @(negedge ui_clk); drive(I_CAL | I_BV, 28'h0, 2'b00, 8'h00);
      @(negedge ui_clk); drive(I_CAL, 28'h0, 2'b00, 8'h00);
      #1 chk("timeout_sticky", 128'({o_timeout, o_done}), 128'({1'b1, 1'b1}));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
